// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and address helpers for the scoreboarded register file.
// Pure constants and functions: no logic, no latency.
package reg_file_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_MAX_PEND = 3;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_pend);
        return (max_pend > 0) ? $clog2(max_pend + 1) : 1;
    endfunction

    function automatic logic addr_ok(input int addr, input int n);
        return addr < n;
    endfunction

endpackage

// File: rtl/reg_file_sb_counter.sv
// Saturating up/down pending-write counter; clr wins, inc+dec together hold.
// State visible one cycle after the edge; a dec at zero is dropped.
module sb_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         dec_ok;
    logic         inc_ok;

    always_comb begin
        cnt_d  = cnt_q;
        dec_ok = dec && (cnt_q != '0);
        // An increment at the ceiling is only legal when a retire frees a slot.
        inc_ok = inc && ((cnt_q != W'(MAX)) || dec_ok);
        if (clr) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == W'(MAX));

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard and optional write bypass.
// Reads combinational; writes and scoreboard updates visible the cycle after the edge.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int BYPASS   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_RD*addr_w(NUM_REGS)-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]             rd_data,
    output logic [NUM_RD-1:0]                    rd_busy,
    input  logic                                 issue_en,
    input  logic [addr_w(NUM_REGS)-1:0]          issue_dest,
    output logic                                 issue_stall,
    input  logic                                 wr_en,
    input  logic [addr_w(NUM_REGS)-1:0]          wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 flush
);

    localparam int ADDR_W = addr_w(NUM_REGS);
    localparam int CNT_W  = cnt_w(MAX_PEND);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  pend   [NUM_REGS];
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    logic issue_in_rng;
    logic wr_in_rng;
    logic full_dest;
    logic issue_acc;

    assign issue_in_rng = addr_ok(32'(issue_dest), NUM_REGS);
    assign wr_in_rng    = addr_ok(32'(wr_addr), NUM_REGS);
    assign full_dest    = issue_in_rng ? full[issue_dest] : 1'b0;
    // A same-cycle retire to the destination frees the slot the new issue needs.
    assign issue_stall  = issue_en && issue_in_rng && full_dest &&
                          !(wr_en && (wr_addr == issue_dest));
    assign issue_acc    = issue_en && issue_in_rng && !issue_stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        assign inc[r] = issue_acc && (issue_dest == ADDR_W'(r));
        assign dec[r] = wr_en && (wr_addr == ADDR_W'(r));

        sb_counter #(
            .MAX (MAX_PEND),
            .W   (CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[r]),
            .dec  (dec[r]),
            .clr  (flush),
            .cnt  (pend[r]),
            .full (full[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_in_rng) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= DATA_W'(r);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              in_rng;
        logic              fwd;
        logic [DATA_W-1:0] dat;
        logic              busy;

        always_comb begin
            addr   = rd_addr[k*ADDR_W +: ADDR_W];
            in_rng = addr_ok(32'(addr), NUM_REGS);
            // Forwarding is suppressed in reset so reads show the reset image.
            fwd    = (BYPASS != 0) && rst && wr_en && (wr_addr == addr);
            dat    = '0;
            busy   = 1'b0;
            if (in_rng) begin
                dat  = fwd ? wr_data : regs_q[addr];
                busy = (pend[addr] != '0) && !(fwd && (pend[addr] == CNT_W'(1)));
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = dat;
        assign rd_busy[k]                  = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Drives a default instance and a wide no-bypass instance with identical operations
// and compares both against an array-based reference model every cycle.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic issue_en, wr_en, flush;

    logic [7:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [3:0]   a_issue_dest, a_wr_addr;
    logic [31:0]  a_wr_data;
    logic         a_issue_stall;

    logic [14:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [4:0]   b_issue_dest, b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_issue_stall;

    reg_file_sb u_dut_a (
        .clk         (clk),
        .rst         (rst_n),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_busy     (a_rd_busy),
        .issue_en    (issue_en),
        .issue_dest  (a_issue_dest),
        .issue_stall (a_issue_stall),
        .wr_en       (wr_en),
        .wr_addr     (a_wr_addr),
        .wr_data     (a_wr_data),
        .flush       (flush)
    );

    reg_file_sb #(
        .DATA_W   (64),
        .NUM_REGS (32),
        .NUM_RD   (3),
        .MAX_PEND (3),
        .BYPASS   (0)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst_n),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_busy     (b_rd_busy),
        .issue_en    (issue_en),
        .issue_dest  (b_issue_dest),
        .issue_stall (b_issue_stall),
        .wr_en       (wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .flush       (flush)
    );

    int total = 0;
    int bad   = 0;

    int          s_rd [3];
    int          s_dest, s_wa;
    logic [63:0] s_wd;
    logic        s_ie, s_we, s_fl;

    logic [63:0] m_regs [2][32];
    int          m_pend [2][32];

    function automatic int nregs(input int i);
        return (i == 0) ? 16 : 32;
    endfunction

    function automatic int nrd(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int byp(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [63:0] dmask(input int i);
        return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic exp_stall(input int i);
        int d, w;
        d = s_dest % nregs(i);
        w = s_wa % nregs(i);
        return rst_n && s_ie && (m_pend[i][d] == 3) && !(s_we && (w == d));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        issue_en     = s_ie;
        wr_en        = s_we;
        flush        = s_fl;
        a_issue_dest = 4'(s_dest % 16);
        b_issue_dest = 5'(s_dest % 32);
        a_wr_addr    = 4'(s_wa % 16);
        b_wr_addr    = 5'(s_wa % 32);
        a_wr_data    = s_wd[31:0];
        b_wr_data    = s_wd;
        for (int k = 0; k < 2; k++) a_rd_addr[k*4 +: 4] = 4'(s_rd[k] % 16);
        for (int k = 0; k < 3; k++) b_rd_addr[k*5 +: 5] = 5'(s_rd[k] % 32);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[i][r] = 64'(r);
                m_pend[i][r] = 0;
            end
        end
    endtask

    task automatic model_edge();
        int  w, d;
        logic st, ret;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            w   = s_wa % nregs(i);
            d   = s_dest % nregs(i);
            st  = exp_stall(i);
            ret = s_we && (m_pend[i][w] > 0);
            if (s_we) m_regs[i][w] = s_wd & dmask(i);
            if (s_fl) begin
                for (int r = 0; r < 32; r++) m_pend[i][r] = 0;
            end else begin
                if (s_ie && !st) m_pend[i][d] = m_pend[i][d] + 1;
                if (ret)         m_pend[i][w] = m_pend[i][w] - 1;
            end
        end
    endtask

    task automatic check(input string tag);
        int          a;
        logic        fwd, eb, ob;
        logic [63:0] ed, od;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < nrd(i); k++) begin
                a   = s_rd[k] % nregs(i);
                fwd = rst_n && (byp(i) != 0) && s_we && ((s_wa % nregs(i)) == a);
                ed  = fwd ? (s_wd & dmask(i)) : m_regs[i][a];
                eb  = (m_pend[i][a] != 0) && !(fwd && (m_pend[i][a] == 1));
                od  = (i == 0) ? {32'b0, a_rd_data[k*32 +: 32]} : b_rd_data[k*64 +: 64];
                ob  = (i == 0) ? a_rd_busy[k] : b_rd_busy[k];
                chk($sformatf("%s.i%0d.p%0d.dat", tag, i, k), od, ed);
                chk($sformatf("%s.i%0d.p%0d.busy", tag, i, k), 64'(ob), 64'(eb));
            end
            chk($sformatf("%s.i%0d.stall", tag, i),
                64'((i == 0) ? a_issue_stall : b_issue_stall), 64'(exp_stall(i)));
        end
    endtask

    task automatic set(input int ie, input int dest, input int we, input int wa,
                       input logic [63:0] wd, input int fl, input int r0, input int r1, input int r2);
        s_ie   = (ie != 0);
        s_dest = dest;
        s_we   = (we != 0);
        s_wa   = wa;
        s_wd   = wd;
        s_fl   = (fl != 0);
        s_rd[0] = r0;
        s_rd[1] = r1;
        s_rd[2] = r2;
    endtask

    task automatic step(input string tag);
        drive();
        @(negedge clk);
        check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set(0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset image must show through even with a write and issue asserted.
        set(1, 5, 1, 5, 64'd99, 0, 5, 15, 31);
        drive();
        #1;
        check("rst");
        @(posedge clk);
        #1;
        check("rst_hold");
        set(0, 0, 0, 0, 64'h0, 0, 5, 15, 31);
        rst_n = 1'b1;
        step("rd5_15");
        chk("lit_r5", {32'b0, a_rd_data[31:0]}, 64'd5);
        chk("lit_r15", {32'b0, a_rd_data[63:32]}, 64'd15);
        chk("lit_r31", b_rd_data[191:128], 64'd31);

        set(1, 3, 0, 0, 64'h0, 0, 3, 3, 3);            step("iss3");
        set(0, 0, 0, 0, 64'h0, 0, 3, 5, 3);            step("busy3");
        set(0, 0, 1, 3, 64'hDEADBEEF, 0, 3, 3, 3);     step("wb3");
        set(0, 0, 0, 0, 64'h0, 0, 3, 3, 3);            step("clr3");
        chk("lit_r3_a", {32'b0, a_rd_data[31:0]}, 64'hDEADBEEF);
        chk("lit_r3_b", b_rd_data[63:0], 64'hDEADBEEF);
        chk("lit_r3_busy", 64'({a_rd_busy, b_rd_busy}), 64'd0);

        for (int j = 0; j < 3; j++) begin
            set(1, 7, 0, 0, 64'h0, 0, 7, 7, 7);        step("iss7");
        end
        set(1, 7, 0, 0, 64'h0, 0, 7, 7, 7);
        drive();
        #1;
        chk("lit_stall7", 64'({a_issue_stall, b_issue_stall}), 64'd3);
        step("stall7");
        set(1, 7, 1, 7, 64'h77, 0, 7, 7, 7);           step("stall7_wr");
        set(0, 0, 0, 0, 64'h0, 0, 7, 7, 7);            step("pend7");
        set(1, 7, 0, 0, 64'h0, 0, 7, 7, 7);            step("stall7_again");
        set(0, 0, 0, 0, 64'h0, 1, 7, 7, 7);            step("flush7");

        set(1, 2, 0, 0, 64'h0, 0, 2, 4, 9);            step("iss2");
        set(1, 4, 0, 0, 64'h0, 0, 2, 4, 9);            step("iss4");
        set(1, 2, 1, 9, 64'h55, 1, 2, 4, 9);           step("flush_wr9");
        set(0, 0, 0, 0, 64'h0, 0, 2, 4, 9);            step("after_flush");
        chk("lit_r9", b_rd_data[191:128], 64'h55);
        chk("lit_flush_busy", 64'({a_rd_busy, b_rd_busy}), 64'd0);

        set(1, 8, 0, 0, 64'h0, 0, 6, 8, 6);            step("iss8");
        set(1, 6, 0, 0, 64'h0, 0, 6, 8, 6);            step("iss6");
        set(0, 0, 1, 6, 64'h1234, 0, 6, 8, 6);
        drive();
        @(negedge clk);
        check("wr6_pre");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async");
        chk("lit_r6_rst", {32'b0, a_rd_data[31:0]}, 64'd6);
        @(posedge clk);
        #1;
        check("rst_edge");
        set(0, 0, 0, 0, 64'h0, 0, 6, 8, 6);
        rst_n = 1'b1;
        step("post_rst");
        chk("lit_r6_post", b_rd_data[63:0], 64'd6);

        for (int n = 0; n < 400; n++) begin
            s_ie    = ($urandom_range(0, 1) == 1);
            s_dest  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            s_we    = ($urandom_range(0, 2) == 0);
            s_wa    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            s_wd    = {$urandom, $urandom};
            s_fl    = ($urandom_range(0, 23) == 0);
            for (int k = 0; k < 3; k++) begin
                s_rd[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
